// File: rtl/bip_fetch_unit.sv
// bip_fetch_unit: instruction fetch unit for the BIP processor.
//   Holds the PC, issues single reads to a synchronous program memory, and
//   hands each captured instruction to the decoder over a valid/ready handshake.
//   Latency: start in cycle t -> imem_rd in t+1 -> instr_valid in t+3.
//   Throughput: 3 cycles per instruction when instr_ready stays high.
//   Backpressure: instr, pc and instr_valid hold while instr_ready is low.
//   Fetching stops for good once a HALT opcode is accepted; only reset resumes.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   start                 - begin fetching from address 0 (honoured only in IDLE)
//   imem_addr, imem_rd    - registered memory read address and one-cycle strobe
//   imem_data             - memory read data, valid the cycle after imem_rd
//   instr, instr_valid    - instruction to the decoder and its valid flag
//   instr_ready           - decoder accepts instr when instr_valid is high
//   pc                    - address of the instruction currently held in instr
//   halted                - HALT accepted, fetch stopped
//   instr_count           - saturating count of accepted instructions
module bip_fetch_unit #(
  parameter int                    len         = 16,
  parameter int                    addr_len    = 11,
  parameter int                    opcode_len  = 5,
  parameter logic [opcode_len-1:0] halt_opcode = '0,
  parameter int                    cnt_len     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [addr_len-1:0] imem_addr,
  output logic                imem_rd,
  input  logic [len-1:0]      imem_data,
  output logic [len-1:0]      instr,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [addr_len-1:0] pc,
  output logic                halted,
  output logic [cnt_len-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t state;

  logic [opcode_len-1:0] opcode;
  logic [addr_len-1:0]   pc_next;
  logic [cnt_len-1:0]    count_next;
  logic                  count_full;

  assign opcode     = instr[len-1 -: opcode_len];
  // Wraps modulo 2^addr_len with no indication.
  assign pc_next    = pc + {{(addr_len-1){1'b0}}, 1'b1};
  assign count_full = &instr_count;
  assign count_next = count_full ? instr_count
                                 : instr_count + {{(cnt_len-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      imem_addr   <= '0;
      imem_rd     <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // pc is always 0 here, so this launches the read of address 0.
          if (start) begin
            imem_rd   <= 1'b1;
            imem_addr <= pc;
            state     <= S_FETCH;
          end
        end

        S_FETCH: begin
          // The strobe is a single-cycle pulse; data returns next cycle.
          imem_rd <= 1'b0;
          state   <= S_WAIT;
        end

        S_WAIT: begin
          instr       <= imem_data;
          instr_valid <= 1'b1;
          state       <= S_ISSUE;
        end

        S_ISSUE: begin
          if (instr_valid && instr_ready) begin
            instr_count <= count_next;
            instr_valid <= 1'b0;
            if (opcode == halt_opcode) begin
              halted <= 1'b1;
              state  <= S_HALTED;
            end else begin
              // Next read is launched directly from the handshake so the
              // FETCH cycle already shows the new address and strobe.
              pc        <= pc_next;
              imem_addr <= pc_next;
              imem_rd   <= 1'b1;
              state     <= S_FETCH;
            end
          end
        end

        S_HALTED: begin
          imem_rd     <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end

        default: begin
          state       <= S_IDLE;
          imem_rd     <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
